bus_irq_cond: RTL
=================

# bus_irq_cond

Interrupt source conditioner placed directly upstream of the interrupt register. It takes up to DATAWIDTH raw, asynchronous event lines from board logic, synchronizes them into the bus clock domain, and rejects glitches with a per-channel stability filter. For each channel it selects the qualifying event (rising edge, falling edge, both edges, or level) and emits a registered `trig` vector. The interrupt register consumes `trig` by OR-ing it into its pending bits.

## Interface
Parameters:
- DATAWIDTH, 32, number of channels
- SYNC_STAGES, 2, synchronizer flops per channel (legal 2..4)
- FILTER_CYCLES, 4, consecutive stable cycles required to accept a new input level (legal 1..255; 1 = no filtering beyond sync)

Ports:
- bus_clk  in  1  bus clock; every flop in the block uses it
- bus_reset_l  in  1  reset; asynchronous, active-low
- raw  in  DATAWIDTH  asynchronous event lines
- mode  in  2*DATAWIDTH  per-channel edge select, channel i at bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- level  in  DATAWIDTH  per-channel level mode; 1 overrides `mode` for that channel
- trig  out  DATAWIDTH  registered interrupt requests to the interrupt register
- state  out  DATAWIDTH  filtered level of each channel, for status readback

`mode` and `level` are quasi-static configuration driven from bus registers in the bus_clk domain.

## Operation
Each channel is independent and built from identical logic.
- **Synchronizer:** `raw[i]` passes through a SYNC_STAGES flop chain; the last stage is `s[i]`.
- **Filter:** there is one counter per channel, width ceil(log2(FILTER_CYCLES)) with a minimum of 1 bit. The filter compares `s[i]` with `state[i]` each cycle.
  - If they are equal, the counter clears to 0.
  - If they differ and counter == FILTER_CYCLES-1, then `state[i]` <= `s[i]` and the counter clears.
  - If they differ otherwise, the counter increments.
  - Consequence: a change on `s[i]` lasting fewer than FILTER_CYCLES cycles never reaches `state[i]`.
- **Event detect:** this stage acts on the registered transition of `state[i]` (previous versus new value), never on `raw` or `s` directly.
  - rise = `state` goes 0 to 1.
  - fall = `state` goes 1 to 0.
  - `trig[i]` next value:
    - `level[i]` = 1: `trig[i]` <= `state[i]`, asserted every cycle while the channel is filtered high.
    - else mode 01: rise.
    - else mode 10: fall.
    - else mode 11: rise | fall.
    - else mode 00: 0.
- Edge-mode pulses are exactly 1 cycle wide. A full pulse on `raw` yields one trig in rising or falling mode and two trigs in both mode.
- The filter and `state` track the input even when mode = 00 and level = 0. Enabling a channel while its `state` is already high produces no rising trig; only later transitions count.
- Configuration changes take effect on the next clock edge and never create a trig by themselves. The exception is level mode, which asserts `trig[i]` on the next edge if `state[i]` = 1.

## Timing
- **Reset** (asynchronous assert, synchronous release by the system): the following clear to 0 immediately:
  - all synchronizer flops
  - all filter counters
  - `state`
  - `trig`
  - the previous-state registers
- A line held high through reset therefore produces a rising event after reset release. This is intentional: it reports lines already asserted at power-up.
- **Latency:** let edge 1 be the first edge that samples a new `raw` level. Then:
  - `s` changes after edge SYNC_STAGES.
  - `state` changes at edge SYNC_STAGES+FILTER_CYCLES.
  - `trig` asserts after edge SYNC_STAGES+FILTER_CYCLES+1.
  - With the defaults, `trig` is high in the cycle following edge 7.
- **Reset mid-operation:** an in-progress filter count is discarded, and a `trig` pulse in flight drops immediately on reset assertion.
- **Input toggling every cycle:** the counter clears continuously and `state` holds. No trig is produced.
- **Throughput:** back-to-back accepted transitions on one channel are separated by at least FILTER_CYCLES cycles. Both-mode trigs on one channel are therefore never adjacent when FILTER_CYCLES > 1.
- **Multiple channels:** any number of channels may assert `trig` in the same cycle.

## Test plan
All scenarios use the default parameters unless stated otherwise.
1. **Reset and basic rise:** hold reset, then release with `raw` = 0 and mode[1:0] = 01. Raise `raw[0]` before edge 1. Required: `trig[0]` is 0 through edge 6, high exactly in the cycle after edge 7, then 0; `state[0]` = 1 from edge 6.
2. **Glitch rejection:** channel 1 in mode 11.
   - A 3-cycle high pulse on `raw[1]` gives no trig and `state[1]` stays 0.
   - A 4-cycle pulse gives one trig for the rise, then one trig for the fall 4 cycles later.
3. **Mode coverage:** drive the same 10-cycle pulse on channels 2..5 with modes 00/01/10/11.
   - Required trig counts: 0 / 1 / 1 / 2.
   - Set `level[6]` = 1 with the same pulse: `trig[6]` is high for exactly 10 consecutive cycles.
4. **Enable after assertion:** hold `raw[7]` high for 20 cycles with mode 00, then switch to 01. Required: no trig. Lower the line, then raise it again: exactly one trig.
5. **Reset mid-operation:** start a rise on `raw[8]` and assert reset at edge 5. Required: `trig` and `state` are 0 immediately. Release reset with `raw[8]` still high: trig after edge 7 counted from the first post-reset sampling edge.
6. **Parameters and width:** set FILTER_CYCLES = 1 and SYNC_STAGES = 3 with all 32 channels in mode 01, and raise every `raw` bit simultaneously. Required: `trig` = 32'hFFFFFFFF for one cycle, after edge 5.

Source files
------------

// File: rtl/bus_irq_cond.sv
// bus_irq_cond - interrupt source conditioner feeding the interrupt register.
//
// Each raw, asynchronous event line is synchronized into bus_clk, passed
// through a stability filter, and turned into a registered trigger according
// to its per-channel configuration (rising / falling / both edges / level).
//
// Ports:
//   bus_clk      bus clock, drives every flop
//   bus_reset_l  asynchronous active-low reset
//   raw          [DATAWIDTH]     asynchronous event lines
//   mode         [2*DATAWIDTH]   per-channel edge select {00 off,01 rise,10 fall,11 both}
//   level        [DATAWIDTH]     per-channel level mode, overrides mode
//   trig         [DATAWIDTH]     registered interrupt requests
//   state        [DATAWIDTH]     filtered level of each channel

// One conditioner channel: sync chain, filter, event select.
module bus_irq_cond_lane #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       raw_i,
  input  logic [1:0] mode_i,
  input  logic       level_i,
  output logic       trig_o,
  output logic       state_o
);
  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   prev_q;
  logic                   trig_q, trig_d;
  logic                   s, rise, fall;

  assign s = sync_q[SYNC_STAGES-1];

  // Filter: any disagreement must persist FILTER_CYCLES cycles in a row
  // before it is accepted; agreement at any point restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (s == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      state_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Edges come from the filtered state only. prev_q always tracks state_q,
  // so enabling a channel whose state is already high cannot fake a rise.
  assign rise = state_q & ~prev_q;
  assign fall = ~state_q & prev_q;

  always_comb begin
    trig_d = 1'b0;
    if (level_i) begin
      trig_d = state_q;
    end else begin
      unique case (mode_i)
        2'b01:   trig_d = rise;
        2'b10:   trig_d = fall;
        2'b11:   trig_d = rise | fall;
        default: trig_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      prev_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q   <= cnt_d;
      state_q <= state_d;
      prev_q  <= state_q;
      trig_q  <= trig_d;
    end
  end

  assign trig_o  = trig_q;
  assign state_o = state_q;
endmodule

module bus_irq_cond #(
  parameter int DATAWIDTH     = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                   bus_clk,
  input  logic                   bus_reset_l,
  input  logic [DATAWIDTH-1:0]   raw,
  input  logic [2*DATAWIDTH-1:0] mode,
  input  logic [DATAWIDTH-1:0]   level,
  output logic [DATAWIDTH-1:0]   trig,
  output logic [DATAWIDTH-1:0]   state
);
  for (genvar i = 0; i < DATAWIDTH; i++) begin : g_lane
    bus_irq_cond_lane #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_lane (
      .clk_i  (bus_clk),
      .rst_ni (bus_reset_l),
      .raw_i  (raw[i]),
      .mode_i (mode[2*i+1:2*i]),
      .level_i(level[i]),
      .trig_o (trig[i]),
      .state_o(state[i])
    );
  end
endmodule
